// File: rtl/serial_tx_piso.sv
// Parallel-in/serial-out transmitter: start bit (0), DATA_W data bits LSB
// first, stop bit (1). Each bit is held on tx_out for CLKS_PER_BIT clocks.
module serial_tx_piso #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              busy
);

  // state    | meaning
  // ST_IDLE  | line high, tx_ready asserted, waiting for an accept
  // ST_START | start bit (0) on the line
  // ST_DATA  | data bits, LSB first, from shift_q[0]
  // ST_STOP  | stop bit (1) on the line

  // A one-clock bit period still needs a 1-bit counter to keep widths legal.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(DATA_W + 1);

  localparam logic [CNT_W-1:0] CLK_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              tx_out_q, tx_out_d;
  logic              busy_q, busy_d;

  logic              accept;
  logic              bit_end;
  logic [DATA_W-1:0] shift_nxt;

  // Ready is gated by rst so it drops the instant reset is applied.
  assign tx_ready  = rst && (state_q == ST_IDLE);
  assign accept    = tx_valid && tx_ready;
  assign bit_end   = (clk_cnt_q == CLK_LAST);
  // Shifting by an operator (not a slice) keeps DATA_W=1 legal.
  assign shift_nxt = shift_q >> 1;

  assign tx_out = tx_out_q;
  assign busy   = busy_q;

  // Next-state logic; tx_out_d/busy_d anticipate the level of the next state
  // so the registered outputs line up with the state they describe.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    tx_out_d  = tx_out_q;
    busy_d    = busy_q;

    unique case (state_q)
      ST_IDLE: begin
        tx_out_d = 1'b1;
        busy_d   = 1'b0;
        if (accept) begin
          shift_d   = tx_data;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = ST_START;
          tx_out_d  = 1'b0;
          busy_d    = 1'b1;
        end
      end

      ST_START: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          state_d   = ST_DATA;
          tx_out_d  = shift_q[0];
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          shift_d   = shift_nxt;
          if (bit_cnt_q == BIT_LAST) begin
            state_d  = ST_STOP;
            tx_out_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            tx_out_d  = shift_nxt[0];
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      ST_STOP: begin
        tx_out_d = 1'b1;
        if (bit_end) begin
          clk_cnt_d = '0;
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d   = ST_IDLE;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        tx_out_d  = 1'b1;
        busy_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any frame in flight at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      tx_out_q  <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      tx_out_q  <= tx_out_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_serial_tx_piso.sv
// Bench for serial_tx_piso: one instance at CLKS_PER_BIT=4, one at 1.
module tb_serial_tx_piso;

  logic       clk;
  logic       rst;
  logic       v4, v1;
  logic [7:0] d4, d1;
  logic       rdy4, rdy1, tx4, tx1, busy4, busy1;

  int checks = 0;
  int errors = 0;

  logic exp_q[$];

  serial_tx_piso #(.DATA_W(8), .CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .tx_valid(v4), .tx_data(d4),
    .tx_ready(rdy4), .tx_out(tx4), .busy(busy4)
  );

  serial_tx_piso #(.DATA_W(8), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .tx_valid(v1), .tx_data(d1),
    .tx_ready(rdy1), .tx_out(tx1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference frame: list of bit levels, each repeated cpb times.
  task automatic build_frame(input logic [7:0] d, input int cpb);
    logic lvl;
    for (int b = 0; b < 10; b++) begin
      if (b == 0)      lvl = 1'b0;
      else if (b == 9) lvl = 1'b1;
      else             lvl = d[b-1];
      for (int c = 0; c < cpb; c++) exp_q.push_back(lvl);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic [7:0] d);
    if (sel) begin v1 = v; d1 = d; end
    else     begin v4 = v; d4 = d; end
  endtask

  task automatic wait_ready(input bit sel);
    int n = 0;
    while (!(sel ? rdy1 : rdy4) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", sel ? rdy1 : rdy4, 1'b1);
  endtask

  // One accept, then check every cycle of the frame and the idle cycle after.
  // Pulses of tx_valid at frame cycles pa/pb must be ignored.
  task automatic run_frame(input bit sel, input logic [7:0] d, input int pa, input int pb);
    exp_q.delete();
    build_frame(d, sel ? 1 : 4);
    @(negedge clk);
    wait_ready(sel);
    drive(sel, 1'b1, d);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 8'($urandom));
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      chk("frame_tx",    sel ? tx1 : tx4,     exp_q[k]);
      chk("frame_busy",  sel ? busy1 : busy4, 1'b1);
      chk("frame_ready", sel ? rdy1 : rdy4,   1'b0);
      if (k == pa || k == pb) drive(sel, 1'b1, 8'h00);
      else                    drive(sel, 1'b0, 8'($urandom));
    end
    @(negedge clk);
    drive(sel, 1'b0, 8'h00);
    chk("post_tx",    sel ? tx1 : tx4,     1'b1);
    chk("post_busy",  sel ? busy1 : busy4, 1'b0);
    chk("post_ready", sel ? rdy1 : rdy4,   1'b1);
  endtask

  initial begin
    rst = 1'b0;
    v4 = 1'b0; v1 = 1'b0; d4 = 8'h00; d1 = 8'h00;

    // Reset values while inputs toggle.
    repeat (3) begin
      @(negedge clk);
      chk("rst_tx4",  tx4,   1'b1);
      chk("rst_rdy4", rdy4,  1'b0);
      chk("rst_bsy4", busy4, 1'b0);
      chk("rst_tx1",  tx1,   1'b1);
      chk("rst_rdy1", rdy1,  1'b0);
      chk("rst_bsy1", busy1, 1'b0);
      v4 = 1'($urandom); d4 = 8'($urandom);
      v1 = 1'($urandom); d1 = 8'($urandom);
    end
    @(posedge clk);
    #1;
    v4 = 1'b0; v1 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rel_rdy4", rdy4, 1'b1);
    chk("rel_rdy1", rdy1, 1'b1);
    chk("rel_tx4",  tx4,  1'b1);

    // Single frame, then the same frame with ignored pulses.
    run_frame(1'b0, 8'hA5, -1, -1);
    run_frame(1'b0, 8'hA5, 5, 20);

    // Back-to-back with tx_valid held high.
    exp_q.delete();
    build_frame(8'h3C, 4);
    exp_q.push_back(1'b1);
    build_frame(8'hFF, 4);
    @(negedge clk);
    wait_ready(1'b0);
    v4 = 1'b1; d4 = 8'h3C;
    @(posedge clk);
    #1;
    d4 = 8'hFF;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      chk("b2b_tx",   tx4,   exp_q[k]);
      chk("b2b_busy", busy4, (k != 40));
      chk("b2b_rdy",  rdy4,  (k == 40));
      if (k == 41) v4 = 1'b0;
    end
    @(negedge clk);
    chk("b2b_end_tx",  tx4,  1'b1);
    chk("b2b_end_rdy", rdy4, 1'b1);

    // Reset between edges in the middle of a frame.
    exp_q.delete();
    build_frame(8'hA5, 4);
    @(negedge clk);
    wait_ready(1'b0);
    v4 = 1'b1; d4 = 8'hA5;
    @(posedge clk);
    #1;
    v4 = 1'b0;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      chk("mid_tx", tx4, exp_q[k]);
    end
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_tx",   tx4,   1'b1);
    chk("mid_rst_busy", busy4, 1'b0);
    chk("mid_rst_rdy",  rdy4,  1'b0);
    @(posedge clk);
    #1;
    chk("mid_hold_tx", tx4, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rel_rdy", rdy4, 1'b1);
    run_frame(1'b0, 8'h01, -1, -1);

    // Minimum bit period.
    run_frame(1'b1, 8'h80, -1, -1);

    // Randomized words and ignored-pulse positions.
    repeat (6) run_frame(1'b0, 8'($urandom), int'($urandom_range(0, 38)), int'($urandom_range(0, 38)));
    repeat (6) run_frame(1'b1, 8'($urandom), int'($urandom_range(0, 8)), -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_tx_piso.md
Name: serial_tx_piso

Overview:
Parallel-in/serial-out transmitter. Accepts a DATA_W-bit word over a valid/ready handshake and shifts it out on a single line. Frame is one start bit (0), DATA_W data bits LSB first, then one stop bit (1). Each bit is held for CLKS_PER_BIT clocks. Drives the serial line that our flop-based capture/receive blocks sample.

Parameters:
DATA_W, 8, data bits per frame (>=1)
CLKS_PER_BIT, 4, clock cycles each bit is held on tx_out (>=1)

Ports:
clk  input  1  single system clock, rising-edge active
rst  input  1  reset, asynchronous, active-low (0 = reset)
tx_valid  input  1  tx_data is presented for transmission
tx_data  input  DATA_W  word to transmit
tx_ready  output  1  block can accept a word this cycle
tx_out  output  1  serial line, idle high
busy  output  1  frame in progress (START/DATA/STOP)

Behaviour:
- One clock; reset is asynchronous and active-low. rst=0 forces the following immediately, without waiting for a clock edge: state=IDLE, tx_out=1, tx_ready=0, busy=0, shift register=0, counters=0.
- tx_ready=1 only when state=IDLE and rst=1. It may be combinational from state and rst.
- tx_out is a registered output, with no combinational path from inputs.
- FSM states:
  - IDLE: tx_out=1, busy=0. tx_valid=1 with tx_ready=1 at an edge is an accept: latch tx_data into the shift register, clear bit_cnt and clk_cnt, go to START.
  - START: tx_out=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx_out=shift_reg[0]. Each bit is held CLKS_PER_BIT cycles, then shift right. After DATA_W bits, go to STOP.
  - STOP: tx_out=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Latency: tx_out falls at the same edge that registers the accept. The first cycle of the start bit is the cycle after the accept cycle.
- Frame length is exactly (DATA_W+2)*CLKS_PER_BIT cycles.
- Back-to-back: IDLE is occupied for at least 1 cycle between frames, so there is a minimum gap of 1 idle-high cycle.
- busy=1 exactly while state is START, DATA or STOP. It is registered and aligned with tx_out.
- tx_valid and tx_data while tx_ready=0 are ignored. No queuing, no effect on the frame in flight.
- tx_data changing after the accept does not affect the frame in flight.
- Counter widths:
  - clk_cnt: $clog2(CLKS_PER_BIT), minimum 1 bit; wraps to 0 at CLKS_PER_BIT-1.
  - bit_cnt: $clog2(DATA_W+1); no overflow.
- CLKS_PER_BIT=1: every bit lasts one cycle, and the FSM advances every cycle.
- Reset mid-frame: the frame is dropped. tx_out goes to 1 immediately. After rst is released, the first edge finds IDLE, with tx_ready=1 in that cycle.
- Accept in the same cycle rst deasserts: treated as a normal accept at the first edge where rst=1.
- No X on outputs at any time after reset has been asserted once.

Test Plan:
1. Reset values: hold rst=0 for 3 cycles while toggling tx_valid and tx_data -> tx_out=1, tx_ready=0, busy=0 throughout. Release -> tx_ready=1 at the next cycle.
2. Single frame: DATA_W=8, CLKS_PER_BIT=4, tx_data=8'hA5, one accept.
   - Required tx_out, each level held 4 cycles: 0, 1,0,1,0,0,1,0,1, 1.
   - busy=1 for exactly 40 cycles; tx_ready returns to 1 after them.
3. Back-to-back: tx_valid held high with 8'h3C then 8'hFF. Required sequence:
   - 0, 0,0,1,1,1,1,0,0, 1 (3C frame)
   - then 1 idle cycle high
   - then 0, eight 1s, 1 (FF frame)
4. Ignore while busy: during the 8'hA5 frame, pulse tx_valid with 8'h00 at cycles 5 and 20 -> serial output identical to scenario 2; no second frame.
5. Reset mid-frame: assert rst=0 asynchronously at cycle 17 of the 8'hA5 frame, between edges -> tx_out=1 before the next edge, busy=0. Release, send 8'h01 -> clean frame 0, 1,0,0,0,0,0,0,0, 1.
6. Minimum timing: CLKS_PER_BIT=1, DATA_W=8, tx_data=8'h80 -> 10-cycle frame 0,0,0,0,0,0,0,0,1,1. tx_ready=1 in cycle 11 after the accept.
